// File: rtl/serial_add_pkg.sv
// Shared types and sizing helpers for the bit-serial adder controller.
package serial_add_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADD  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Bit counter must hold 0..N-1 without wrapping inside one add.
  function automatic int cnt_width(input int n);
    return (n < 1) ? 1 : $clog2(n + 1);
  endfunction

endpackage

// File: rtl/full_adder_str.sv
// Structural one-bit full adder cell, shared by the ripple and serial adders.
module full_adder_str (
  input  logic x,
  input  logic y,
  input  logic cin,
  output logic s,
  output logic cout
);

  logic xy_x;
  logic xy_a;
  logic cx_a;

  assign xy_x = x ^ y;
  assign xy_a = x & y;
  assign cx_a = cin & xy_x;
  assign s    = xy_x ^ cin;
  assign cout = xy_a | cx_a;

endmodule

// File: rtl/serial_add_ctrl.sv
// Bit-serial adder: one full_adder_str cell sequenced over N cycles, LSB first,
// with a start/busy/done handshake.
module serial_add_ctrl
  import serial_add_pkg::*;
#(
  parameter int N = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         cin,
  output logic         busy,
  output logic         done,
  output logic [N-1:0] sum,
  output logic         cout
);

  localparam int CW = cnt_width(N);

  state_t        state, state_nxt;
  logic [N-1:0]  sa, sb;
  logic          carry;
  logic [CW-1:0] count;
  logic          fa_s, fa_co;
  logic          last_bit;
  logic [N-1:0]  sum_shift;

  full_adder_str u_fa (
    .x    (sa[0]),
    .y    (sb[0]),
    .cin  (carry),
    .s    (fa_s),
    .cout (fa_co)
  );

  assign last_bit  = (count == CW'(N - 1));
  // New sum bit enters at the MSB; written as shift/or so N=1 needs no slice.
  assign sum_shift = (sum >> 1) | (N'(fa_s) << (N - 1));

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (start) state_nxt = ADD;
      ADD:     if (last_bit) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign busy = (state == ADD) || (state == DONE);
  assign done = (state == DONE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      sa    <= '0;
      sb    <= '0;
      carry <= 1'b0;
      count <= '0;
      sum   <= '0;
      cout  <= 1'b0;
    end else begin
      state <= state_nxt;
      unique case (state)
        IDLE: begin
          if (start) begin
            sa    <= a;
            sb    <= b;
            carry <= cin;
            count <= '0;
            sum   <= '0;
          end
        end
        ADD: begin
          sa    <= sa >> 1;
          sb    <= sb >> 1;
          sum   <= sum_shift;
          carry <= fa_co;
          count <= count + CW'(1);
          if (last_bit) cout <= fa_co;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Scoreboard bench for serial_add_ctrl at N=8 and N=1.
module tb_serial_add_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst8, start8, cin8, busy8, done8, cout8;
  logic [7:0] a8, b8, sum8;
  logic       rst1, start1, cin1, busy1, done1, cout1;
  logic [0:0] a1, b1, sum1;

  serial_add_ctrl #(.N(8)) dut8 (
    .clk(clk), .rst(rst8), .start(start8), .a(a8), .b(b8), .cin(cin8),
    .busy(busy8), .done(done8), .sum(sum8), .cout(cout8)
  );

  serial_add_ctrl #(.N(1)) dut1 (
    .clk(clk), .rst(rst1), .start(start1), .a(a1), .b(b1), .cin(cin1),
    .busy(busy1), .done(done1), .sum(sum1), .cout(cout1)
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int phase = 0;
  int start_cyc = -100;
  int ph3_last = -1;
  int ph3_cnt = 0;
  bit n1_done = 1'b0;
  bit pd8 = 1'b0;
  bit pd1 = 1'b0;
  logic [8:0] q8[$];
  logic [1:0] q1[$];

  initial forever @(posedge clk) cyc++;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Monitor: pops the scoreboard whenever a done pulse is presented.
  initial forever @(negedge clk) begin
    if (rst8) begin
      chk("rst8_busy", int'(busy8), 0);
      chk("rst8_done", int'(done8), 0);
      chk("rst8_sum", int'(sum8), 0);
      chk("rst8_cout", int'(cout8), 0);
      pd8 = 1'b0;
    end else begin
      if (phase == 1 && cyc == start_cyc) chk("busy8_rise", int'(busy8), 1);
      if (done8) begin
        chk("done8_width", int'(pd8), 0);
        if (q8.size() == 0) chk("done8_spurious", 1, 0);
        else chk("sum8", int'({cout8, sum8}), int'(q8.pop_front()));
        if (phase == 1) chk("done8_latency", cyc - start_cyc, 8);
        if (phase == 3) begin
          if (ph3_last >= 0) chk("done8_period", cyc - ph3_last, 10);
          ph3_last = cyc;
          ph3_cnt++;
        end
      end
      pd8 = done8;
    end
    if (rst1) begin
      chk("rst1_busy", int'(busy1), 0);
      chk("rst1_sum", int'({cout1, sum1}), 0);
      pd1 = 1'b0;
    end else begin
      if (done1) begin
        chk("done1_width", int'(pd1), 0);
        if (q1.size() == 0) chk("done1_spurious", 1, 0);
        else chk("sum1", int'({cout1, sum1}), int'(q1.pop_front()));
      end
      pd1 = done1;
    end
  end

  task automatic op8(input logic [7:0] a, input logic [7:0] b, input logic c,
                     input logic [8:0] exp);
    @(negedge clk);
    start8 = 1'b1; a8 = a; b8 = b; cin8 = c;
    start_cyc = cyc + 1;
    q8.push_back(exp);
    @(negedge clk);
    start8 = 1'b0;
  endtask

  task automatic wait_idle8();
    int k = 0;
    while (busy8 && k < 40) begin
      @(negedge clk);
      k++;
    end
    if (k >= 40) chk("idle8_timeout", k, 0);
  endtask

  // N=1 driver runs alongside the N=8 sequence.
  initial begin
    rst1 = 1'b1; start1 = 1'b0; a1 = '0; b1 = '0; cin1 = 1'b0;
    repeat (2) @(negedge clk);
    rst1 = 1'b0;
    for (int i = 0; i < 1000; i++) begin
      logic [0:0] ra, rb;
      logic rc;
      int k;
      ra = 1'($urandom); rb = 1'($urandom); rc = 1'($urandom);
      @(negedge clk);
      start1 = 1'b1; a1 = ra; b1 = rb; cin1 = rc;
      q1.push_back(2'(ra) + 2'(rb) + 2'(rc));
      @(negedge clk);
      start1 = 1'b0;
      k = 0;
      while (busy1 && k < 20) begin
        @(negedge clk);
        k++;
      end
      if (k >= 20) chk("idle1_timeout", k, 0);
    end
    n1_done = 1'b1;
  end

  initial begin
    int k;
    rst8 = 1'b1; start8 = 1'b0; a8 = '0; b8 = '0; cin8 = 1'b0;
    repeat (2) @(negedge clk);
    rst8 = 1'b0;

    phase = 1;
    op8(8'h5A, 8'h3C, 1'b0, 9'h096);
    wait_idle8();
    phase = 2;
    op8(8'hFF, 8'h01, 1'b0, 9'h100);
    wait_idle8();

    // start pulses in ADD and DONE with churning operands must be ignored
    op8(8'h37, 8'h4C, 1'b1, 9'h084);
    for (int i = 0; i <= 8; i++) begin
      start8 = (i == 2 || i == 8);
      a8 = (i == 2) ? 8'h11 : 8'($urandom);
      b8 = (i == 2) ? 8'h22 : 8'($urandom);
      cin8 = 1'($urandom);
      @(negedge clk);
    end
    start8 = 1'b0;
    wait_idle8();
    repeat (3) @(negedge clk);

    op8(8'hFF, 8'hFF, 1'b1, 9'h1FF);
    wait_idle8();

    // asynchronous reset in the 4th ADD cycle discards the operation
    op8(8'h5A, 8'h3C, 1'b0, 9'h096);
    repeat (3) @(posedge clk);
    #2;
    rst8 = 1'b1;
    q8.delete();
    @(negedge clk);
    @(negedge clk);
    rst8 = 1'b0;
    op8(8'h01, 8'h01, 1'b0, 9'h002);
    wait_idle8();

    // start held high: back-to-back adds at E0, E10, E20
    phase = 3;
    ph3_last = -1;
    @(negedge clk);
    start8 = 1'b1; a8 = 8'h80; b8 = 8'h80; cin8 = 1'b0;
    repeat (3) q8.push_back(9'h100);
    repeat (30) @(negedge clk);
    start8 = 1'b0;
    wait_idle8();
    phase = 2;
    chk("ph3_done_count", ph3_cnt, 3);

    for (int i = 0; i < 1000; i++) begin
      logic [7:0] ra, rb;
      logic rc;
      ra = 8'($urandom); rb = 8'($urandom); rc = 1'($urandom);
      op8(ra, rb, rc, 9'(ra) + 9'(rb) + 9'(rc));
      wait_idle8();
    end

    k = 0;
    while (!n1_done && k < 20000) begin
      @(negedge clk);
      k++;
    end
    if (k >= 20000) chk("n1_timeout", k, 0);
    repeat (3) @(negedge clk);
    chk("q8_empty", q8.size(), 0);
    chk("q1_empty", q1.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
